// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the pipelined MIPS datapath.
// Two combinational read ports and two prioritised write ports (port 1 wins a
// same-address collision). It also holds a pending-write scoreboard: a
// reserve marks a register as awaiting a port-1 result, and a port-1 write
// retires that mark. A registered pending count tracks the population of the
// scoreboard so the hazard unit can tell cheaply whether anything is in flight.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              busy0,
    output logic              busy1,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [CNT_W-1:0]  pending_cnt_q;
    logic [CNT_W-1:0]  pending_cnt_d;

    logic we0_eff_s;
    logic we1_eff_s;
    logic rsv_eff_s;
    logic set_s;
    logic clr_s;

    // Register 0 swallows writes and reserves when it is hard-wired to zero.
    assign we0_eff_s = we0 & ~(ZERO_REG & (wa0 == ADDR_ZERO));
    assign we1_eff_s = we1 & ~(ZERO_REG & (wa1 == ADDR_ZERO));
    assign rsv_eff_s = rsv_en & ~(ZERO_REG & (rsv_addr == ADDR_ZERO));

    // One read port: returns {busy, data}. Priority is zero register, then
    // the port-1 bypass (which also hides the pending bit being retired),
    // then the port-0 bypass, then the stored state.
    function automatic logic [DATA_W:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              pend,
        input logic              w1_eff,
        input logic [ADDR_W-1:0] w1_addr,
        input logic [DATA_W-1:0] w1_data,
        input logic              w0_eff,
        input logic [ADDR_W-1:0] w0_addr,
        input logic [DATA_W-1:0] w0_data
    );
        logic [DATA_W:0] res;
        if (ZERO_REG && (ra == ADDR_ZERO)) begin
            res = {1'b0, DATA_ZERO};
        end else if (BYPASS && w1_eff && (w1_addr == ra)) begin
            res = {1'b0, w1_data};
        end else if (BYPASS && w0_eff && (w0_addr == ra)) begin
            res = {pend, w0_data};
        end else begin
            res = {pend, stored};
        end
        return res;
    endfunction

    assign {busy0, rd0} = read_port(ra0, mem_q[ra0], pend_q[ra0],
                                    we1_eff_s, wa1, wd1, we0_eff_s, wa0, wd0);
    assign {busy1, rd1} = read_port(ra1, mem_q[ra1], pend_q[ra1],
                                    we1_eff_s, wa1, wd1, we0_eff_s, wa0, wd0);

    // Next storage contents: port 1 overrides port 0 on a shared address.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we1_eff_s && (wa1 == ADDR_W'(i))) begin
                mem_d[i] = wd1;
            end else if (we0_eff_s && (wa0 == ADDR_W'(i))) begin
                mem_d[i] = wd0;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Next scoreboard: a reserve beats a same-address retire (new producer wins).
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_eff_s && (rsv_addr == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
            end else if (we1_eff_s && (wa1 == ADDR_W'(i))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Incremental pending count: +1 only for a fresh reservation, -1 only for
    // a retire that is not immediately re-reserved, so it never drifts from
    // the population of the scoreboard.
    always_comb begin
        set_s         = rsv_eff_s & ~pend_q[rsv_addr];
        clr_s         = we1_eff_s & pend_q[wa1] & ~(rsv_eff_s & (rsv_addr == wa1));
        pending_cnt_d = pending_cnt_q + CNT_W'(set_s) - CNT_W'(clr_s);
    end

    // State registers with synchronous active-low reset; reset beats any
    // write or reserve sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_ZERO;
            end
            pend_q        <= {DEPTH{1'b0}};
            pending_cnt_q <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q        <= pend_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign pending_cnt = pending_cnt_q;

endmodule
